// File: rtl/seg7_scan_ctrl.sv
// Multi-digit 7-segment scan controller with hex/decimal conversion.
// Display content changes only at frame wrap so a frame never tears.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_W-1:0]     number,
  input  logic                  mode,
  input  logic                  blank_lz,
  output logic [7:0]            cathode_array,
  output logic [NUM_DIGITS-1:0] anode_array,
  output logic                  busy,
  output logic                  overflow
);

  localparam int BCD_DIGITS = (DATA_W * 3) / 10 + 2;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int EXT_W      = 4 * (NUM_DIGITS + BCD_DIGITS);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W      = $clog2(REFRESH_DIV);
  localparam int CNT_W      = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_COMMIT
  } state_t;

  typedef logic [NUM_DIGITS-1:0][6:0] codes_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   num_q, num_d;
  logic                mode_q, mode_d;
  logic                blank_q, blank_d;
  logic                captured_q, captured_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  codes_t              pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic                pend_ovf_q, pend_ovf_d;
  codes_t              disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]          cathode_q, cathode_d;

  logic [EXT_W-1:0]    src;
  logic                ovf_c;
  logic                keep;
  logic [3:0]          nib;
  codes_t              code;
  logic [NUM_DIGITS-1:0] on;
  logic                tc;
  logic                wrap;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  function automatic logic [BCD_W-1:0] dabble(
    input logic [BCD_W-1:0] b,
    input logic             bit_in
  );
    logic [BCD_W-1:0] t;
    t = b;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (t[4*k +: 4] >= 4'd5) t[4*k +: 4] = t[4*k +: 4] + 4'd3;
    end
    return {t[BCD_W-2:0], bit_in};
  endfunction

  // Digit codes from the shadow value; only latched in COMMIT.
  always_comb begin
    src   = mode_q ? EXT_W'(bcd_q) : EXT_W'(num_q);
    ovf_c = |(src >> (4 * NUM_DIGITS));
    keep  = 1'b0;
    nib   = '0;
    code  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = src[4*i +: 4];
      if (nib != 4'd0) keep = 1'b1;
      if (ovf_c) code[i] = 7'h40;
      else if (blank_q && !keep && i != 0) code[i] = 7'h00;
      else code[i] = glyph(nib);
    end
  end

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    mode_d       = mode_q;
    blank_d      = blank_q;
    captured_d   = captured_q;
    busy_d       = busy_q;
    sh_d         = sh_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    pend_ovf_d   = pend_ovf_q;
    disp_d       = disp_q;
    ovf_d        = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (!captured_q || number != num_q ||
            mode != mode_q || blank_lz != blank_q) begin
          num_d      = number;
          mode_d     = mode;
          blank_d    = blank_lz;
          captured_d = 1'b1;
          busy_d     = 1'b1;
          sh_d       = number;
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = mode ? S_CONVERT : S_COMMIT;
        end
      end
      S_CONVERT: begin
        bcd_d = dabble(bcd_q, sh_q[DATA_W-1]);
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        pend_d     = code;
        pend_ovf_d = ovf_c;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tc    = (div_q == DIV_W'(REFRESH_DIV - 1));
    wrap  = tc && (idx_q == IDX_W'(NUM_DIGITS - 1));
    div_d = tc ? '0 : div_q + DIV_W'(1);
    idx_d = idx_q;
    if (tc) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

    // Wrap consumes the old pending; a same-cycle commit re-arms valid.
    if (wrap && pend_valid_q) begin
      disp_d       = pend_q;
      ovf_d        = pend_ovf_q;
      pend_valid_d = 1'b0;
    end
    if (state_q == S_COMMIT) pend_valid_d = 1'b1;

    on        = '0;
    on[idx_q] = 1'b1;
    anode_d   = (ACTIVE_LOW != 0) ? ~on : on;
    cathode_d = (ACTIVE_LOW != 0) ? ~{1'b0, disp_q[idx_q]}
                                  : {1'b0, disp_q[idx_q]};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      mode_q       <= 1'b0;
      blank_q      <= 1'b0;
      captured_q   <= 1'b0;
      busy_q       <= 1'b0;
      sh_q         <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_ovf_q   <= 1'b0;
      disp_q       <= '0;
      ovf_q        <= 1'b0;
      idx_q        <= '0;
      div_q        <= '0;
      anode_q      <= (ACTIVE_LOW != 0) ? '1 : '0;
      cathode_q    <= (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      mode_q       <= mode_d;
      blank_q      <= blank_d;
      captured_q   <= captured_d;
      busy_q       <= busy_d;
      sh_q         <= sh_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      pend_ovf_q   <= pend_ovf_d;
      disp_q       <= disp_d;
      ovf_q        <= ovf_d;
      idx_q        <= idx_d;
      div_q        <= div_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
    end
  end

  assign anode_array   = anode_q;
  assign cathode_array = cathode_q;
  assign busy          = busy_q;
  assign overflow      = ovf_q;

endmodule
